// File: rtl/optical_4x4_cfg_sched_pkg.sv
// Shared definitions for the 4x4 optical switch configuration scheduler:
// FSM state encoding, 2x2 element bar/cross constants and port/destination widths.
package optical_4x4_cfg_sched_pkg;

  localparam int unsigned NUM_PORTS = 4;
  localparam int unsigned DST_W     = 2;
  localparam int unsigned PERM_W    = NUM_PORTS * DST_W;
  localparam int unsigned CTRL_W    = 6;
  localparam int unsigned CNT_W     = 8;

  // 2x2 element drive values
  localparam logic BAR   = 1'b0;
  localparam logic CROSS = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_COLLECT  = 3'd1,
    S_CHECK    = 3'd2,
    S_ISSUE    = 3'd3,
    S_WAIT_GNT = 3'd4,
    S_SETTLE   = 3'd5,
    S_DONE     = 3'd6
  } state_e;

endpackage

// File: rtl/optical_4x4_cfg_sched_if.sv
// Request/grant bus of the configuration scheduler.
// master: request source + grant stage (drives i_*), slave: scheduler (drives o_*).
//   i_port_req/i_port_dst   per-port request strobe and destination
//   o_port_ack/o_port_nack  per-port accept/reject pulses
//   o_4x4_req/o_4x4_valid   permutation to the grant stage
//   i_switch_grant/i_grant_valid  bar/cross vector back from the grant stage
//   o_switch_ctrl           drive to the six 2x2 elements
//   o_config_end, o_busy    round status
interface optical_4x4_cfg_sched_if;
  import optical_4x4_cfg_sched_pkg::*;

  logic [NUM_PORTS-1:0] i_port_req;
  logic [PERM_W-1:0]    i_port_dst;
  logic [NUM_PORTS-1:0] o_port_ack;
  logic [NUM_PORTS-1:0] o_port_nack;
  logic [PERM_W-1:0]    o_4x4_req;
  logic                 o_4x4_valid;
  logic [CTRL_W-1:0]    i_switch_grant;
  logic                 i_grant_valid;
  logic [CTRL_W-1:0]    o_switch_ctrl;
  logic                 o_config_end;
  logic                 o_busy;

  modport master (
    output i_port_req, i_port_dst, i_switch_grant, i_grant_valid,
    input  o_port_ack, o_port_nack, o_4x4_req, o_4x4_valid,
           o_switch_ctrl, o_config_end, o_busy
  );

  modport slave (
    input  i_port_req, i_port_dst, i_switch_grant, i_grant_valid,
    output o_port_ack, o_port_nack, o_4x4_req, o_4x4_valid,
           o_switch_ctrl, o_config_end, o_busy
  );

endinterface

// File: rtl/optical_perm_fill.sv
// Combinational conflict resolution and fill for one scheduling round.
//   dst_in : per-port requested destination, port n at [2n+1:2n]
//   pend   : per-port pending mask
//   perm   : resulting legal permutation
//   lose   : pending ports that lost a destination conflict
module optical_perm_fill
  import optical_4x4_cfg_sched_pkg::*;
(
  input  logic [PERM_W-1:0]    dst_in,
  input  logic [NUM_PORTS-1:0] pend,
  output logic [PERM_W-1:0]    perm,
  output logic [NUM_PORTS-1:0] lose
);

  logic [NUM_PORTS-1:0] keep;
  logic [NUM_PORTS-1:0] used;
  logic                 found;

  // Lowest-index pending port keeps a contested destination; the rest are filled
  // in ascending port order with the lowest destination nobody kept.
  always_comb begin
    lose  = '0;
    perm  = dst_in;
    used  = '0;
    found = 1'b0;
    for (int n = 1; n < NUM_PORTS; n++) begin
      for (int m = 0; m < n; m++) begin
        if (pend[n] && pend[m] &&
            (dst_in[m*DST_W +: DST_W] == dst_in[n*DST_W +: DST_W])) begin
          lose[n] = 1'b1;
        end
      end
    end
    keep = pend & ~lose;
    for (int n = 0; n < NUM_PORTS; n++) begin
      if (keep[n]) used[dst_in[n*DST_W +: DST_W]] = 1'b1;
    end
    for (int n = 0; n < NUM_PORTS; n++) begin
      if (!keep[n]) begin
        found = 1'b0;
        for (int d = 0; d < NUM_PORTS; d++) begin
          if (!found && !used[d]) begin
            perm[n*DST_W +: DST_W] = DST_W'(d);
            used[d]                = 1'b1;
            found                  = 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/optical_4x4_cfg_sched.sv
// Configuration scheduler for a 4x4 optical switch built from six 2x2 elements.
// Collects per-port destination requests, resolves them into a permutation,
// hands it to the grant stage, applies the returned bar/cross vector and waits
// for the elements to settle.
//   i_clk, i_rst : clock, asynchronous active-high reset
//   bus          : optical_4x4_cfg_sched_if.slave (request/grant bus)
// Optional build macro OPT_SCHED_TIMEOUT_EN: collection also ends P_COLLECT_TO
// cycles after it started, with unrequested ports filled.
module optical_4x4_cfg_sched
  import optical_4x4_cfg_sched_pkg::*;
#(
  parameter int unsigned P_SETTLE_CYC = 16,
  parameter int unsigned P_COLLECT_TO = 32
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  optical_4x4_cfg_sched_if.slave         bus
);

  state_e               state_q, state_d;
  logic [NUM_PORTS-1:0] pend_q, pend_d;
  logic [PERM_W-1:0]    dst_q, dst_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [NUM_PORTS-1:0] ack_q, ack_d, nack_q, nack_d;
  logic [PERM_W-1:0]    req4_q, req4_d;
  logic                 valid_q, valid_d, end_q, end_d, busy_q, busy_d;
  logic [CTRL_W-1:0]    ctrl_q, ctrl_d;
  logic [PERM_W-1:0]    perm_c;
  logic [NUM_PORTS-1:0] lose_c;
  logic                 accepting_c;
  logic                 collect_exit_c;

  optical_perm_fill u_fill (
    .dst_in (dst_q),
    .pend   (pend_q),
    .perm   (perm_c),
    .lose   (lose_c)
  );

  assign accepting_c = (state_q == S_IDLE) || (state_q == S_COLLECT);

`ifdef OPT_SCHED_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(P_COLLECT_TO + 1);
  logic [TO_W-1:0] to_cnt_q;

  // Counts cycles spent in COLLECT since entry
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                    to_cnt_q <= '0;
    else if (state_q == S_COLLECT) to_cnt_q <= to_cnt_q + TO_W'(1);
    else                          to_cnt_q <= '0;
  end

  assign collect_exit_c = (&pend_q) ||
                          ((to_cnt_q == TO_W'(P_COLLECT_TO - 1)) && (|pend_q));
`else
  assign collect_exit_c = &pend_q;
`endif

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (|bus.i_port_req) state_d = S_COLLECT;
      S_COLLECT:  if (collect_exit_c)  state_d = S_CHECK;
      S_CHECK:    state_d = S_ISSUE;
      S_ISSUE:    state_d = S_WAIT_GNT;
      S_WAIT_GNT: if (bus.i_grant_valid) state_d = S_SETTLE;
      S_SETTLE:   if (cnt_q == CNT_W'(P_SETTLE_CYC - 1)) state_d = S_DONE;
      S_DONE:     state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // Next values of datapath and output registers
  always_comb begin
    pend_d  = pend_q;
    dst_d   = dst_q;
    cnt_d   = '0;
    ack_d   = '0;
    nack_d  = '0;
    req4_d  = req4_q;
    valid_d = 1'b0;
    ctrl_d  = ctrl_q;
    end_d   = (state_d == S_DONE);
    busy_d  = (state_d != S_IDLE) && (state_d != S_COLLECT);

    if (accepting_c) begin
      ack_d  = bus.i_port_req;
      pend_d = pend_q | bus.i_port_req;
      for (int n = 0; n < NUM_PORTS; n++) begin
        if (bus.i_port_req[n]) dst_d[n*DST_W +: DST_W] = bus.i_port_dst[n*DST_W +: DST_W];
      end
    end else begin
      nack_d = bus.i_port_req;
    end

    case (state_q)
      S_CHECK: begin
        nack_d  = nack_d | lose_c;
        pend_d  = pend_q & ~lose_c;
        req4_d  = perm_c;
        valid_d = 1'b1;
      end
      S_WAIT_GNT: if (bus.i_grant_valid) ctrl_d = bus.i_switch_grant;
      S_SETTLE:   cnt_d = cnt_q + CNT_W'(1);
      S_DONE:     pend_d = '0;
      default:    ;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pend_q  <= '0;
      dst_q   <= '0;
      cnt_q   <= '0;
      ack_q   <= '0;
      nack_q  <= '0;
      req4_q  <= '0;
      valid_q <= 1'b0;
      ctrl_q  <= {CTRL_W{BAR}};
      end_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      pend_q  <= pend_d;
      dst_q   <= dst_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      nack_q  <= nack_d;
      req4_q  <= req4_d;
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      end_q   <= end_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.o_port_ack    = ack_q;
  assign bus.o_port_nack   = nack_q;
  assign bus.o_4x4_req     = req4_q;
  assign bus.o_4x4_valid   = valid_q;
  assign bus.o_switch_ctrl = ctrl_q;
  assign bus.o_config_end  = end_q;
  assign bus.o_busy        = busy_q;

endmodule
